// File: rtl/counter_nbit.sv
// Up/down counter with terminal count MAX_VALUE, optional saturation and parallel load.
// Define COUNTER_NBIT_EDGE_DETECT_EN to step on 0->1 edges of Increase/Decrease instead of levels.
module counter_nbit #(
  parameter int WIDTH     = 4,
  parameter int MAX_VALUE = 2**WIDTH - 1,
  parameter bit SATURATE  = 1'b0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Increase,
  input  logic             Decrease,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  output logic [WIDTH-1:0] Count,
  output logic             Carry,
  output logic             Borrow,
  output logic             AtMax,
  output logic             AtMin
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VALUE);

  logic             inc_ev;
  logic             dec_ev;
  logic [WIDTH-1:0] count_nxt;
  logic             carry_nxt;
  logic             borrow_nxt;

`ifdef COUNTER_NBIT_EDGE_DETECT_EN
  logic inc_q;
  logic dec_q;

  // History tracks the raw inputs on every non-reset cycle, Load cycles included.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      inc_q <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      inc_q <= Increase;
      dec_q <= Decrease;
    end
  end

  assign inc_ev = Increase & ~inc_q;
  assign dec_ev = Decrease & ~dec_q;
`else
  assign inc_ev = Increase;
  assign dec_ev = Decrease;
`endif

  always_comb begin
    count_nxt  = Count;
    carry_nxt  = 1'b0;
    borrow_nxt = 1'b0;
    if (Load) begin
      count_nxt = (LoadValue > MAX_CNT) ? MAX_CNT : LoadValue;
    end else if (inc_ev && !dec_ev) begin
      if (Count < MAX_CNT) begin
        count_nxt = Count + WIDTH'(1);
      end else if (!SATURATE) begin
        count_nxt = '0;
        carry_nxt = 1'b1;
      end
    end else if (dec_ev && !inc_ev) begin
      if (Count != '0) begin
        count_nxt = Count - WIDTH'(1);
      end else if (!SATURATE) begin
        count_nxt  = MAX_CNT;
        borrow_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Count  <= '0;
      Carry  <= 1'b0;
      Borrow <= 1'b0;
    end else begin
      Count  <= count_nxt;
      Carry  <= carry_nxt;
      Borrow <= borrow_nxt;
    end
  end

  assign AtMax = (Count == MAX_CNT);
  assign AtMin = (Count == '0);

endmodule

// File: tb/tb_counter_nbit.sv
// Self-checking bench: a wrapping and a saturating counter (MAX_VALUE=9) driven with the same
// stimulus and compared every cycle against an arithmetic reference model.
module tb_counter_nbit;

  localparam int W   = 4;
  localparam int MAX = 9;

`ifdef COUNTER_NBIT_EDGE_DETECT_EN
  localparam bit EDGE_MODE = 1'b1;
`else
  localparam bit EDGE_MODE = 1'b0;
`endif

  logic         Clock = 1'b0;
  logic         Reset;
  logic         Increase;
  logic         Decrease;
  logic         Load;
  logic [W-1:0] LoadValue;

  logic [W-1:0] count_w, count_s;
  logic         carry_w, carry_s, borrow_w, borrow_s;
  logic         atmax_w, atmax_s, atmin_w, atmin_s;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: index 0 = wrapping, index 1 = saturating.
  int m_cnt[2];
  int m_carry[2];
  int m_borrow[2];
  bit inc_prev, dec_prev;

  always #5 Clock = ~Clock;

  counter_nbit #(.WIDTH(W), .MAX_VALUE(MAX), .SATURATE(1'b0)) u_wrap (
    .Clock(Clock), .Reset(Reset), .Increase(Increase), .Decrease(Decrease),
    .Load(Load), .LoadValue(LoadValue), .Count(count_w), .Carry(carry_w),
    .Borrow(borrow_w), .AtMax(atmax_w), .AtMin(atmin_w)
  );

  counter_nbit #(.WIDTH(W), .MAX_VALUE(MAX), .SATURATE(1'b1)) u_sat (
    .Clock(Clock), .Reset(Reset), .Increase(Increase), .Decrease(Decrease),
    .Load(Load), .LoadValue(LoadValue), .Count(count_s), .Carry(carry_s),
    .Borrow(borrow_s), .AtMax(atmax_s), .AtMin(atmin_s)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_step(input bit rst, input bit ld, input bit inc, input bit dec,
                            input int lv);
    bit ie, de;
    ie = EDGE_MODE ? (inc && !inc_prev) : inc;
    de = EDGE_MODE ? (dec && !dec_prev) : dec;
    for (int s = 0; s < 2; s++) begin
      m_carry[s]  = 0;
      m_borrow[s] = 0;
      if (rst) m_cnt[s] = 0;
      else if (ld) m_cnt[s] = (lv > MAX) ? MAX : lv;
      else if (ie && !de) begin
        if (!(s == 1 && m_cnt[s] == MAX)) begin
          m_cnt[s]   = (m_cnt[s] + 1) % (MAX + 1);
          m_carry[s] = (m_cnt[s] == 0);
        end
      end else if (de && !ie) begin
        if (!(s == 1 && m_cnt[s] == 0)) begin
          m_cnt[s]    = (m_cnt[s] + MAX) % (MAX + 1);
          m_borrow[s] = (m_cnt[s] == MAX);
        end
      end
    end
    inc_prev = rst ? 1'b0 : inc;
    dec_prev = rst ? 1'b0 : dec;
  endtask

  task automatic compare_all();
    check("wrap.count",  int'(count_w),  m_cnt[0]);
    check("wrap.carry",  int'(carry_w),  m_carry[0]);
    check("wrap.borrow", int'(borrow_w), m_borrow[0]);
    check("wrap.atmax",  int'(atmax_w),  int'(m_cnt[0] == MAX));
    check("wrap.atmin",  int'(atmin_w),  int'(m_cnt[0] == 0));
    check("sat.count",   int'(count_s),  m_cnt[1]);
    check("sat.carry",   int'(carry_s),  m_carry[1]);
    check("sat.borrow",  int'(borrow_s), m_borrow[1]);
    check("sat.atmax",   int'(atmax_s),  int'(m_cnt[1] == MAX));
    check("sat.atmin",   int'(atmin_s),  int'(m_cnt[1] == 0));
  endtask

  task automatic cycle(input bit rst, input bit ld, input bit inc, input bit dec, input int lv);
    Reset     = rst;
    Load      = ld;
    Increase  = inc;
    Decrease  = dec;
    LoadValue = W'(lv);
    @(posedge Clock);
    model_step(rst, ld, inc, dec, lv);
    #1;
    compare_all();
  endtask

  task automatic pulse_inc();
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic pulse_dec();
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    Reset = 1'b1; Load = 1'b0; Increase = 1'b0; Decrease = 1'b0; LoadValue = '0;
    inc_prev = 1'b0; dec_prev = 1'b0;
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0; m_carry[s] = 0; m_borrow[s] = 0;
    end

    // Reset state
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 7);
    check("reset.count", int'(count_w), 0);
    check("reset.atmin", int'(atmin_w), 1);

    // Ten up pulses: 1..9 then wrap to 0 with Carry
    for (int i = 1; i <= 10; i++) begin
      cycle(0, 0, 1, 0, 0);
      check("up.count", int'(count_w), i % 10);
      check("up.carry", int'(carry_w), int'(i == 10));
      cycle(0, 0, 0, 0, 0);
    end

    // Down from 0 wraps to MAX with Borrow
    cycle(0, 0, 0, 1, 0);
    check("down.count",  int'(count_w),  9);
    check("down.borrow", int'(borrow_w), 1);
    check("down.atmax",  int'(atmax_w),  1);
    cycle(0, 0, 0, 0, 0);
    check("down.borrow_clr", int'(borrow_w), 0);

    // Saturating: Load 9, three up pulses hold at 9
    cycle(0, 1, 0, 0, 9);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0, 0);
      check("sat.hold_max", int'(count_s), 9);
      check("sat.no_carry", int'(carry_s), 0);
      cycle(0, 0, 0, 0, 0);
    end
    cycle(0, 1, 0, 0, 0);
    pulse_dec();
    check("sat.hold_min", int'(count_s), 0);

    // Load clamp with Increase asserted in the same cycle
    cycle(0, 1, 1, 0, 15);
    check("load.clamp", int'(count_w), 9);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 5);
    check("load.value", int'(count_w), 5);

    // Simultaneous up/down holds; reset beats load
    cycle(0, 1, 0, 0, 4);
    cycle(0, 0, 1, 1, 0);
    check("both.count", int'(count_w), 4);
    check("both.carry", int'(carry_w), 0);
    check("both.borrow", int'(borrow_w), 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 7);
    check("rst_vs_load", int'(count_w), 0);

    // Increase held for four cycles
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0);
    check("hold4.count", int'(count_w), EDGE_MODE ? 1 : 4);
    cycle(0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(39) == 0), ($urandom_range(7) == 0),
            $urandom_range(1) == 1, $urandom_range(1) == 1, int'($urandom_range(15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
